// File: rtl/mux_lut_pkg.sv
// Shared types and sizing helpers for the programmable LUT array.
package mux_lut_pkg;

    // Configuration FSM states
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE
    } lut_state_t;

    // Total configuration bits for ch tables of k inputs each
    function automatic int unsigned lut_cfg_bits(input int unsigned k, input int unsigned ch);
        return ch * (32'd1 << k);
    endfunction

endpackage

// File: rtl/lut_mux2.sv
// Basic 2:1 mux cell used as the building block of the LUT mux trees.
module lut_mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/lut_mux_tree.sv
// 2^K:1 mux tree selecting one table bit by a K-bit address.
// Level 1 picks between adjacent table bits using sel[0]; each further
// level halves the candidate set using the next higher address bit.
module lut_mux_tree #(
    parameter int unsigned K = 2
) (
    input  logic [K-1:0]      sel,
    input  logic [(1<<K)-1:0] tbl,
    output logic              y
);

    localparam int unsigned T = 1 << K;

    for (genvar l = 1; l <= K; l++) begin : g_lvl
        logic [(T>>(l-1))-1:0] src;
        logic [(T>>l)-1:0]     v;

        if (l == 1) begin : g_src_tbl
            assign src = tbl;
        end else begin : g_src_lvl
            assign src = g_lvl[l-1].v;
        end

        for (genvar j = 0; j < (T >> l); j++) begin : g_node
            lut_mux2 u_mux (
                .a   (src[2*j]),
                .b   (src[2*j+1]),
                .sel (sel[l-1]),
                .y   (v[j])
            );
        end
    end

    assign y = g_lvl[K].v[0];

endmodule

// File: rtl/mux_lut_array.sv
// Array of CH programmable K-input LUTs loaded through a serial config stream,
// with a registered single-cycle evaluate path.
module mux_lut_array
    import mux_lut_pkg::*;
#(
    parameter int unsigned K  = 2,
    parameter int unsigned CH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_en,
    input  logic            cfg_bit,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [CH*K-1:0] x,
    output logic            out_valid,
    output logic [CH-1:0]   out
);

    localparam int unsigned T     = 1 << K;
    localparam int unsigned TOTAL = lut_cfg_bits(K, CH);
    localparam int unsigned CW    = $clog2(TOTAL + 1);

    lut_state_t       state_q, state_d;
    logic [TOTAL-1:0] cfg_q, cfg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CH-1:0]    lut_y;
    logic             eval;

    // Next-state, shift register and counter; cfg_start always wins over cfg_en
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_en) begin
                    cfg_d = {cfg_q[TOTAL-2:0], cfg_bit};
                    if (cnt_q == CW'(TOTAL - 1)) begin
                        state_d = ACTIVE;
                        cnt_d   = CW'(TOTAL);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Config FSM state, table and bit counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cfg_done = (state_q == ACTIVE);
    assign eval     = (state_q == ACTIVE) && in_valid;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        lut_mux_tree #(
            .K (K)
        ) u_tree (
            .sel (x[c*K +: K]),
            .tbl (cfg_q[c*T +: T]),
            .y   (lut_y[c])
        );
    end

    // Registered evaluate path; out holds its value when no evaluation happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= eval;
            if (eval) begin
                out <= lut_y;
            end
        end
    end

endmodule

// File: doc/mux_lut_array.md
Name: mux_lut_array

Overview:
- Array of CH independent programmable K-input lookup tables. Each table is a 2^K:1 mux tree with a configurable data-input vector.
- Successor to the fixed-constant single-mux gate: any K-input function, including NOT, AND and XOR, is realised by serially loading the truth table at run time.
- Sits between the lab control logic, which drives the config stream, and the datapath, which drives the registered evaluate path.

Parameters:
- K, 2, inputs per LUT (1..6); table size T = 2^K bits.
- CH, 4, number of independent LUT channels.
- TOTAL, CH*2^K (localparam), total configuration bits.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- cfg_start  input  1  one-cycle pulse; begins a new configuration load.
- cfg_en  input  1  config bit strobe, valid only in LOAD.
- cfg_bit  input  1  serial config data, MSB of the config word first.
- cfg_done  output  1  high while a complete table is held (state ACTIVE).
- in_valid  input  1  evaluate request.
- x  input  CH*K  LUT inputs; channel c uses x[c*K +: K].
- out_valid  output  1  registered valid for out.
- out  output  CH  registered LUT results; out[c] is the channel c result.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; cfg word = 0; bit counter = 0; cfg_done = 0; out_valid = 0; out = 0.
- Config word cfg[TOTAL-1:0]: channel c table = cfg[c*T +: T], indexed by address x[c*K +: K].
- Shifting: on each accepted bit, cfg <= {cfg[TOTAL-2:0], cfg_bit}. After TOTAL shifts, the first bit shifted sits in cfg[TOTAL-1].
- States: IDLE, LOAD, ACTIVE (held in shared enum).
- IDLE: cfg_start -> LOAD, counter cleared. cfg_en and in_valid are ignored.
- LOAD: each cycle with cfg_en = 1 shifts one bit and increments the counter.
  - When the TOTAL-th bit is accepted, go to ACTIVE on the same edge; cfg_done reads 1 from the next cycle.
  - cfg_start in LOAD restarts: counter cleared, partial bits remain but are overwritten.
- ACTIVE: cfg_start -> LOAD; cfg_done drops the cycle after the start edge. cfg_en without cfg_start is ignored; extra bits never corrupt the table.
- cfg_start and cfg_en in the same cycle: cfg_start wins. The counter is cleared and that bit is discarded, in every state.
- Counter width: $clog2(TOTAL+1). It never exceeds TOTAL.
- Evaluate:
  - Latency 1. If state is ACTIVE and in_valid = 1, then on the next edge out[c] <= cfg[c*T + x[c*K +: K]] and out_valid <= 1.
  - Otherwise out_valid <= 0 and out holds its last value.
  - in_valid outside ACTIVE is dropped; no error flag.
  - In the cycle cfg_start arrives while ACTIVE, an in_valid is still evaluated with the old table, because the state is still ACTIVE.
- No back-pressure; one result per cycle at full rate.
- Reset mid-LOAD or mid-evaluate: immediate return to the reset values above; the table is lost.

Decomposition:
- Package mux_lut_pkg:
  - state enum lut_state_t {IDLE, LOAD, ACTIVE};
  - helper function lut_cfg_bits(k, ch) returning ch*2**k.
- Sub-module lut_mux_tree:
  - parameter K; ports sel[K-1:0], table[2^K-1:0], y; combinational.
  - Built from a generate tree of the existing 2:1 mux (K levels, 2^K-1 instances).
  - Instantiated CH times by mux_lut_array.
- Top level owns the FSM, config shift register, counter and output registers.

Test Plan (K=2, CH=2, TOTAL=8):
- Reset check: rst_n low, then high with no config, in_valid = 1 -> out_valid stays 0, out = 0, cfg_done = 0.
- NOT/AND load:
  - cfg_start, then shift 1,0,0,0,0,1,0,1 (word 8'h85: ch1 = AND 4'h8, ch0 = NOT x[0] 4'h5) -> cfg_done = 1 after the 8th bit.
  - Sweep x ch0 = 0..3, ch1 = 0..3 -> ch0 out = ~x[0]; ch1 out = 1 only for x = 3. Each result arrives with out_valid one cycle after in_valid.
- Start/bit collision: cfg_start together with cfg_en = 1, then 8 bits of 8'h66 (XOR both channels) -> table 8'h66, so x = 1 or 2 gives 1. The colliding bit is not counted.
- Reconfigure while ACTIVE: in_valid in the cfg_start cycle -> old-table result. Next cycle cfg_done = 0 and in_valid is dropped (out_valid = 0). A 9th cfg_en after load completes is ignored; table unchanged.
- Async reset mid-LOAD after 5 bits -> all outputs 0 immediately, state IDLE. A subsequent full load of 8'h85 works normally.
